// File: rtl/nand_flash_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nand_pkg
// Purpose  : Opcodes, state / output-mode / operation enums and the status
//            byte helper shared by the NAND responder and host-side benches.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package nand_pkg;

  localparam logic [7:0] CMD_READ0  = 8'h00;
  localparam logic [7:0] CMD_READ1  = 8'h30;
  localparam logic [7:0] CMD_PROG0  = 8'h80;
  localparam logic [7:0] CMD_PROG1  = 8'h10;
  localparam logic [7:0] CMD_ERASE0 = 8'h60;
  localparam logic [7:0] CMD_ERASE1 = 8'hD0;
  localparam logic [7:0] CMD_ID     = 8'h90;
  localparam logic [7:0] CMD_STATUS = 8'h70;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD_ADDR, ST_DATA_IN, ST_BUSY, ST_DATA_OUT
  } nand_state_t;

  typedef enum logic [1:0] {
    MODE_NONE, MODE_ID, MODE_STATUS, MODE_PAGE
  } nand_mode_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_READ, OP_PROG, OP_ERASE, OP_ID, OP_RESET
  } nand_op_t;

  // Status register layout: write-protect, ready, ready, zeros, fail
  function automatic logic [7:0] status_byte(input logic nwp, input logic rdy,
                                             input logic fail);
    return {nwp, rdy, rdy, 4'b0000, fail};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nand_flash_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nand_flash_if
// Purpose  : NAND pin bundle between a host (master) and the responder
//            (slave). The shared data bus is resolved here: the device wins
//            while dev_oe is set, otherwise the host value is seen; a bus
//            nobody drives reads as zero and dev_oe is the drive indicator.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface nand_flash_if;
  logic        nand_cle;
  logic        nand_ale;
  logic        nand_nwe;
  logic        nand_nre;
  logic        nand_nce;
  logic        nand_nwp;
  logic        nand_rnb;
  logic [15:0] host_data;
  logic        host_oe;
  logic [15:0] dev_data;
  logic        dev_oe;
  logic [15:0] nand_data;

  assign nand_data = dev_oe ? dev_data : (host_oe ? host_data : 16'h0000);

  modport slave (
    input  nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp, nand_data,
    output nand_rnb, dev_data, dev_oe
  );

  modport master (
    output nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp,
           host_data, host_oe,
    input  nand_rnb, nand_data, dev_oe
  );
endinterface
`default_nettype wire

// File: rtl/nand_flash_responder_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nand_sync_edge
// Purpose  : Two-flop synchronizer for one asynchronous strobe, with an extra
//            history flop giving single-cycle rise / fall pulses.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module nand_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;
endmodule
`default_nettype wire

// File: rtl/nand_flash_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nand_flash_responder
// Purpose  : Device-side NAND flash model. Decodes synchronized command /
//            address / data cycles, emulates read, program, erase, ID,
//            status and reset against a small on-chip page array.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module nand_flash_responder
  import nand_pkg::*;
#(
  parameter int          PAGE_BYTES = 64,
  parameter int          NUM_PAGES  = 16,
  parameter logic [39:0] ID_BYTES   = 40'h72_15_80_F1_98,
  parameter int          BUSY_READ  = 32,
  parameter int          BUSY_PROG  = 128,
  parameter int          BUSY_ERASE = 96,
  parameter int          BUSY_RESET = 16
) (
  input  logic        clk,
  input  logic        nreset,
  nand_flash_if.slave bus
);
  localparam int COLW = $clog2(PAGE_BYTES);
  localparam int ROWW = $clog2(NUM_PAGES);

  // Copy-out must finish before R/nB rises; column/row come from one byte
  if (BUSY_PROG < PAGE_BYTES) begin : g_chk_prog
    $error("BUSY_PROG must be >= PAGE_BYTES");
  end
  if (BUSY_ERASE < PAGE_BYTES) begin : g_chk_erase
    $error("BUSY_ERASE must be >= PAGE_BYTES");
  end
  if (COLW > 8 || ROWW > 8) begin : g_chk_addr
    $error("PAGE_BYTES and NUM_PAGES must not exceed 256");
  end

  // ---------------- input synchronization ----------------
  logic w_nwe_lvl, w_nwe_rise, w_nwe_fall;
  logic w_nre_lvl, w_nre_rise, w_nre_fall;

  nand_sync_edge #(.RESET_VAL(1'b1)) u_sync_nwe (
    .clk(clk), .nreset(nreset), .i_pin(bus.nand_nwe),
    .o_level(w_nwe_lvl), .o_rise(w_nwe_rise), .o_fall(w_nwe_fall));

  nand_sync_edge #(.RESET_VAL(1'b1)) u_sync_nre (
    .clk(clk), .nreset(nreset), .i_pin(bus.nand_nre),
    .o_level(w_nre_lvl), .o_rise(w_nre_rise), .o_fall(w_nre_fall));

  // Levels and data share the strobes' two-flop delay so they line up
  logic [11:0] r_lvl_meta, r_lvl_sync;
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_lvl_meta <= 12'h200;
      r_lvl_sync <= 12'h200;
    end else begin
      r_lvl_meta <= {bus.nand_cle, bus.nand_ale, bus.nand_nce, bus.nand_nwp,
                     bus.nand_data[7:0]};
      r_lvl_sync <= r_lvl_meta;
    end
  end

  logic       w_cle_s, w_ale_s, w_nce_s, w_nwp_s;
  logic [7:0] w_data_s;
  assign {w_cle_s, w_ale_s, w_nce_s, w_nwp_s, w_data_s} = r_lvl_sync;

  logic w_wr, w_cmd, w_adr, w_dat, w_rd;
  assign w_wr  = w_nwe_rise & ~w_nce_s;
  assign w_cmd = w_wr & w_cle_s & ~w_ale_s;
  assign w_adr = w_wr & w_ale_s & ~w_cle_s;
  assign w_dat = w_wr & ~w_cle_s & ~w_ale_s;
  assign w_rd  = w_nre_rise & ~w_nce_s;

  logic w_unused;
  assign w_unused = &{1'b0, w_nwe_lvl, w_nwe_fall, w_nre_fall, bus.nand_data[15:8]};

  // ---------------- state ----------------
  nand_state_t     r_state, w_state;
  nand_mode_t      r_mode, w_mode, r_prev_mode, w_prev_mode, w_mode_b;
  nand_op_t        r_op, w_op;
  logic [1:0]      r_acnt, w_acnt;
  logic            r_adone, w_adone;
  logic [COLW-1:0] r_col, w_col, r_cidx, w_cidx;
  logic [ROWW-1:0] r_row, w_row;
  logic [2:0]      r_idp, w_idp;
  logic            r_fail, w_fail, r_copy, w_copy;
  logic [31:0]     r_timer, w_timer;
  logic            w_fill, w_bwr, w_mwr, w_rdy;
  logic [7:0]      w_mdata, w_rbyte;

  logic [7:0] r_mem [NUM_PAGES*PAGE_BYTES];
  logic [7:0] r_buf [PAGE_BYTES];

  assign w_rdy   = (r_state != ST_BUSY);
  assign w_mdata = (r_op == OP_ERASE) ? 8'hFF : (r_mem[{r_row, r_cidx}] & r_buf[r_cidx]);

  // Control register bank; everything here clears on reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= ST_IDLE;   r_mode  <= MODE_NONE; r_prev_mode <= MODE_NONE;
      r_op    <= OP_NONE;   r_acnt  <= '0;        r_adone     <= 1'b0;
      r_col   <= '0;        r_row   <= '0;        r_idp       <= '0;
      r_fail  <= 1'b0;      r_timer <= '0;        r_cidx      <= '0;
      r_copy  <= 1'b0;
    end else begin
      r_state <= w_state;   r_mode  <= w_mode;    r_prev_mode <= w_prev_mode;
      r_op    <= w_op;      r_acnt  <= w_acnt;    r_adone     <= w_adone;
      r_col   <= w_col;     r_row   <= w_row;     r_idp       <= w_idp;
      r_fail  <= w_fail;    r_timer <= w_timer;   r_cidx      <= w_cidx;
      r_copy  <= w_copy;
    end
  end

  // Next-state decode: busy countdown/copy, read pointer, bus cycle handling
  always_comb begin
    w_state = r_state; w_mode = r_mode; w_prev_mode = r_prev_mode; w_op = r_op;
    w_acnt  = r_acnt;  w_adone = r_adone; w_col = r_col; w_row = r_row;
    w_idp   = r_idp;   w_fail = r_fail; w_timer = r_timer; w_cidx = r_cidx;
    w_copy  = r_copy;  w_fill = 1'b0;   w_bwr = 1'b0;      w_mwr = 1'b0;
    // A status read only overlays the output mode until the next command
    w_mode_b = (r_mode == MODE_STATUS) ? r_prev_mode : r_mode;

    // With chip enable high the whole device is frozen
    if (!w_nce_s) begin
      if (r_state == ST_BUSY) begin
        if (r_copy) begin
          w_mwr  = 1'b1;
          w_cidx = r_cidx + 1'b1;
          if (r_cidx == COLW'(PAGE_BYTES - 1)) w_copy = 1'b0;
        end
        if (r_timer == 32'd1) begin
          w_timer = '0;
          if (r_op == OP_READ) begin
            w_state = ST_DATA_OUT;
            w_mode  = MODE_PAGE;
          end else begin
            w_state = ST_IDLE;
          end
        end else begin
          w_timer = r_timer - 32'd1;
        end
      end

      if (w_rd) begin
        if (r_mode == MODE_PAGE) w_col = r_col + 1'b1;
        else if (r_mode == MODE_ID) w_idp = (r_idp == 3'd4) ? 3'd0 : r_idp + 3'd1;
      end

      if (w_cmd) begin
        if (w_data_s == CMD_RESET) begin
          w_state = ST_BUSY; w_timer = 32'(BUSY_RESET); w_op = OP_RESET;
          w_copy  = 1'b0;    w_mode  = MODE_NONE;       w_fail = 1'b0;
        end else if (w_data_s == CMD_STATUS) begin
          w_prev_mode = w_mode_b;
          w_mode      = MODE_STATUS;
        end else if (r_state != ST_BUSY) begin
          w_mode = w_mode_b;
          case (w_data_s)
            CMD_READ0, CMD_PROG0, CMD_ERASE0, CMD_ID: begin
              w_state = ST_CMD_ADDR; w_acnt = '0; w_adone = 1'b0;
              w_fail  = 1'b0;        w_mode = MODE_NONE;
              w_op    = (w_data_s == CMD_READ0) ? OP_READ :
                        (w_data_s == CMD_PROG0) ? OP_PROG :
                        (w_data_s == CMD_ERASE0) ? OP_ERASE : OP_ID;
              w_fill  = (w_data_s == CMD_PROG0);
            end
            CMD_READ1: begin
              if (r_state == ST_CMD_ADDR && r_op == OP_READ && r_adone) begin
                w_state = ST_BUSY; w_timer = 32'(BUSY_READ);
              end else begin
                w_state = ST_IDLE;
              end
            end
            CMD_PROG1, CMD_ERASE1: begin
              if ((w_data_s == CMD_PROG1 && r_state == ST_DATA_IN) ||
                  (w_data_s == CMD_ERASE1 && r_state == ST_CMD_ADDR &&
                   r_op == OP_ERASE && r_adone)) begin
                w_state = ST_BUSY;
                w_timer = (w_data_s == CMD_PROG1) ? 32'(BUSY_PROG) : 32'(BUSY_ERASE);
                w_cidx  = '0;
                w_copy  = w_nwp_s;
                if (!w_nwp_s) w_fail = 1'b1;
              end else begin
                w_state = ST_IDLE;
              end
            end
            default: w_state = ST_IDLE;
          endcase
        end
      end else if (w_adr) begin
        if (r_state == ST_CMD_ADDR && !r_adone) begin
          w_acnt = r_acnt + 2'd1;
          case (r_op)
            OP_ID: begin
              w_mode = MODE_ID; w_idp = '0; w_adone = 1'b1; w_state = ST_DATA_OUT;
            end
            OP_ERASE: begin
              if (r_acnt == 2'd0) w_row = w_data_s[ROWW-1:0];
              if (r_acnt == 2'd1) w_adone = 1'b1;
            end
            default: begin
              if (r_acnt == 2'd0) w_col = w_data_s[COLW-1:0];
              if (r_acnt == 2'd2) w_row = w_data_s[ROWW-1:0];
              if (r_acnt == 2'd3) begin
                w_adone = 1'b1;
                if (r_op == OP_PROG) w_state = ST_DATA_IN;
              end
            end
          endcase
        end else if (r_state != ST_BUSY) begin
          w_state = ST_IDLE;
        end
      end else if (w_dat && r_state == ST_DATA_IN) begin
        w_bwr = 1'b1;
        w_col = r_col + 1'b1;
      end
    end
  end

  // Page buffer: preset to erased on program setup, then host data bytes
  always_ff @(posedge clk) begin
    if (w_fill) begin
      for (int i = 0; i < PAGE_BYTES; i++) r_buf[i] <= 8'hFF;
    end else if (w_bwr) begin
      r_buf[r_col] <= w_data_s;
    end
  end

  // Array write port used by the busy-time copy (program AND / erase fill)
  always_ff @(posedge clk) begin
    if (w_mwr) r_mem[{r_row, r_cidx}] <= w_mdata;
  end

  // Read-data selection for the current output mode
  always_comb begin
    w_rbyte = 8'h00;
    case (r_mode)
      MODE_ID:     w_rbyte = ID_BYTES[{r_idp, 3'b000} +: 8];
      MODE_STATUS: w_rbyte = status_byte(w_nwp_s, w_rdy, r_fail);
      MODE_PAGE:   w_rbyte = r_mem[{r_row, r_col}];
      default:     w_rbyte = 8'h00;
    endcase
  end

  assign bus.nand_rnb = w_rdy;
  assign bus.dev_oe   = ~w_nce_s & ~w_nre_lvl & (r_mode != MODE_NONE);
  assign bus.dev_data = {8'h00, w_rbyte};
endmodule
`default_nettype wire

// File: tb/tb_nand_flash_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_nand_flash_responder
// Purpose  : Directed self-checking bench for nand_flash_responder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_nand_flash_responder;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nand_flash_if bus();
  nand_flash_responder dut (.clk(clk), .nreset(nreset), .bus(bus));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write cycle; post = clocks to hold after the nWE rise (0: return at rise)
  task automatic wr(input logic cle, input logic ale, input logic [7:0] d, input int post);
    @(negedge clk);
    bus.nand_cle = cle; bus.nand_ale = ale;
    bus.host_data = {8'h00, d}; bus.host_oe = 1'b1;
    tick(1);
    bus.nand_nwe = 1'b0;
    tick(4);
    bus.nand_nwe = 1'b1;
    if (post > 0) begin
      tick(post);
      bus.nand_cle = 1'b0; bus.nand_ale = 1'b0; bus.host_oe = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] d); wr(1'b1, 1'b0, d, 4); endtask
  task automatic adr(input logic [7:0] d); wr(1'b0, 1'b1, d, 4); endtask
  task automatic dat(input logic [7:0] d); wr(1'b0, 1'b0, d, 4); endtask

  task automatic rd(output logic [15:0] d, output logic oe);
    @(negedge clk);
    bus.nand_nre = 1'b0;
    tick(4);
    d  = bus.nand_data;
    oe = bus.dev_oe;
    bus.nand_nre = 1'b1;
    tick(4);
  endtask

  // Called right after a confirm rise: clocks until R/nB low, then low length
  task automatic measure(output int lat, output int low);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (bus.nand_rnb !== 1'b0 && lat < 8);
    low = 0;
    while (bus.nand_rnb === 1'b0 && low < 2000) begin
      @(negedge clk); low++;
    end
    bus.nand_cle = 1'b0; bus.nand_ale = 1'b0; bus.host_oe = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d; logic oe;
    bus.nand_cle = 0; bus.nand_ale = 0; bus.nand_nwe = 1; bus.nand_nre = 1;
    bus.nand_nce = 0; bus.nand_nwp = 1; bus.host_data = 0; bus.host_oe = 0;
    nreset = 1'b0;
    tick(5);
    nreset = 1'b1;
    tick(4);
    n_cmp++;
    if (bus.nand_rnb !== 1'b1) begin
      $display("FAIL reset_rnb: got %b expected 1", bus.nand_rnb); n_bad++;
    end
    n_cmp++;
    if (bus.dev_oe !== 1'b0) begin
      $display("FAIL reset_oe: got %b expected 0", bus.dev_oe); n_bad++;
    end
    rd(d, oe);
    n_cmp++;
    if (oe !== 1'b0) begin
      $display("FAIL reset_read_oe: got %b expected 0", oe); n_bad++;
    end
  endtask

  task automatic test_read_id;
    logic [7:0] exp [6] = '{8'h98, 8'hF1, 8'h80, 8'h15, 8'h72, 8'h98};
    logic [15:0] d; logic oe;
    cmd(8'h90);
    adr(8'h00);
    for (int i = 0; i < 6; i++) begin
      rd(d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, 8'h00, exp[i]}) begin
        $display("FAIL id_byte[%0d]: got oe=%b %h expected oe=1 %h", i, oe, d, {8'h00, exp[i]});
        n_bad++;
      end
      n_cmp++;
      if ({bus.dev_oe, bus.nand_rnb} !== 2'b01) begin
        $display("FAIL id_gap[%0d]: got oe=%b rnb=%b expected oe=0 rnb=1", i, bus.dev_oe, bus.nand_rnb);
        n_bad++;
      end
    end
  endtask

  task automatic test_erase_read;
    int lat, low, bad;
    logic [15:0] d; logic oe;
    cmd(8'h60); adr(8'h03); adr(8'h00);
    wr(1'b1, 1'b0, 8'hD0, 0);
    measure(lat, low);
    n_cmp++;
    if (lat > 4 || low != 96) begin
      $display("FAIL erase_busy: got fall=%0d low=%0d expected fall<=4 low=96", lat, low); n_bad++;
    end
    cmd(8'h00); adr(8'h00); adr(8'h00); adr(8'h03); adr(8'h00);
    wr(1'b1, 1'b0, 8'h30, 0);
    measure(lat, low);
    n_cmp++;
    if (lat > 4 || low != 32) begin
      $display("FAIL read_busy: got fall=%0d low=%0d expected fall<=4 low=32", lat, low); n_bad++;
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      rd(d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, 16'h00FF}) begin
        if (bad < 4) $display("FAIL erased_byte[%0d]: got oe=%b %h expected oe=1 00ff", i, oe, d);
        bad++; n_bad++;
      end
    end
  endtask

  task automatic test_program;
    logic [7:0] exp [5] = '{8'hFF, 8'hFF, 8'hA5, 8'h5A, 8'hFF};
    int lat, low, n;
    logic [15:0] d; logic oe;
    cmd(8'h80); adr(8'h02); adr(8'h00); adr(8'h03); adr(8'h00);
    dat(8'hA5); dat(8'h5A);
    wr(1'b1, 1'b0, 8'h10, 4);
    bus.nand_cle = 1'b0; bus.host_oe = 1'b0;
    cmd(8'h70);
    rd(d, oe);
    n_cmp++;
    if ({oe, d} !== {1'b1, 16'h0080}) begin
      $display("FAIL status_busy: got oe=%b %h expected oe=1 0080", oe, d); n_bad++;
    end
    n = 0;
    while (bus.nand_rnb !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (bus.nand_rnb !== 1'b1) begin
      $display("FAIL prog_ready: got rnb=%b after %0d clk expected 1", bus.nand_rnb, n); n_bad++;
    end
    rd(d, oe);
    n_cmp++;
    if ({oe, d} !== {1'b1, 16'h00E0}) begin
      $display("FAIL status_ready: got oe=%b %h expected oe=1 00e0", oe, d); n_bad++;
    end
    cmd(8'h00); adr(8'h00); adr(8'h00); adr(8'h03); adr(8'h00);
    wr(1'b1, 1'b0, 8'h30, 0);
    measure(lat, low);
    for (int i = 0; i < 5; i++) begin
      rd(d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, 8'h00, exp[i]}) begin
        $display("FAIL prog_byte[%0d]: got oe=%b %h expected oe=1 %h", i, oe, d, {8'h00, exp[i]});
        n_bad++;
      end
    end
  endtask

  task automatic test_write_protect;
    logic [7:0] exp [4] = '{8'hFF, 8'hFF, 8'hA5, 8'h5A};
    int lat, low;
    logic [15:0] d; logic oe;
    bus.nand_nwp = 1'b0;
    tick(4);
    cmd(8'h80); adr(8'h00); adr(8'h00); adr(8'h03); adr(8'h00);
    dat(8'h00);
    wr(1'b1, 1'b0, 8'h10, 0);
    measure(lat, low);
    n_cmp++;
    if (lat > 4 || low != 128) begin
      $display("FAIL wp_busy: got fall=%0d low=%0d expected fall<=4 low=128", lat, low); n_bad++;
    end
    cmd(8'h70);
    rd(d, oe);
    n_cmp++;
    if ({oe, d} !== {1'b1, 16'h0061}) begin
      $display("FAIL wp_status: got oe=%b %h expected oe=1 0061", oe, d); n_bad++;
    end
    bus.nand_nwp = 1'b1;
    tick(4);
    cmd(8'h00); adr(8'h00); adr(8'h00); adr(8'h03); adr(8'h00);
    wr(1'b1, 1'b0, 8'h30, 0);
    measure(lat, low);
    for (int i = 0; i < 4; i++) begin
      rd(d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, 8'h00, exp[i]}) begin
        $display("FAIL wp_byte[%0d]: got oe=%b %h expected oe=1 %h", i, oe, d, {8'h00, exp[i]});
        n_bad++;
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat, low;
    logic [15:0] d; logic oe;
    cmd(8'h80); adr(8'h00); adr(8'h00); adr(8'h03); adr(8'h00);
    dat(8'h00);
    wr(1'b1, 1'b0, 8'h10, 0);
    tick(20);
    n_cmp++;
    if (bus.nand_rnb !== 1'b0) begin
      $display("FAIL abort_pre_busy: got rnb=%b expected 0", bus.nand_rnb); n_bad++;
    end
    wr(1'b1, 1'b0, 8'hFF, 0);
    measure(lat, low);
    n_cmp++;
    if (lat != 1) begin
      $display("FAIL abort_rnb_low: got first-low sample %0d expected 1", lat); n_bad++;
    end
    n_cmp++;
    if (low < 16 || low > 20) begin
      $display("FAIL abort_busy: got %0d clk after 0xFF expected 16..20", low); n_bad++;
    end
    cmd(8'h70);
    rd(d, oe);
    n_cmp++;
    if ({oe, d} !== {1'b1, 16'h00E0}) begin
      $display("FAIL abort_status: got oe=%b %h expected oe=1 00e0", oe, d); n_bad++;
    end
  endtask

  task automatic test_wrap_nce;
    // col 0 was ANDed with 0x00 before the abort; cols 2,3 hold A5,5A
    logic [7:0] exp [5] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hA5};
    int lat, low;
    logic [15:0] d; logic oe;
    cmd(8'h00); adr(8'h3E); adr(8'h00); adr(8'h03); adr(8'h00);
    wr(1'b1, 1'b0, 8'h30, 0);
    measure(lat, low);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        @(negedge clk); bus.nand_nce = 1'b1;
        tick(4);
        bus.nand_nre = 1'b0;
        tick(4);
        n_cmp++;
        if (bus.dev_oe !== 1'b0) begin
          $display("FAIL nce_oe: got %b expected 0", bus.dev_oe); n_bad++;
        end
        bus.nand_nre = 1'b1;
        tick(4);
        bus.nand_nce = 1'b0;
        tick(4);
      end
      rd(d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, 8'h00, exp[i]}) begin
        $display("FAIL wrap_byte[%0d]: got oe=%b %h expected oe=1 %h", i, oe, d, {8'h00, exp[i]});
        n_bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_erase_read();
    test_program();
    test_write_protect();
    test_reset_abort();
    test_wrap_nce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
